instr_issue_unit: RTL and testbench

Instruction sequencer that feeds the single-cycle datapath/controller pair. Holds a small loadable program store and a program counter, and presents one 32-bit `Instr` per clock. Inserts a one-cycle NOP bubble on load-use hazards and stops on a HALT opcode or at the end of the store. Replaces hand-driven instruction streams at the processor top level.

---
 rtl/instr_issue_unit.sv | 134 +++++++++++++
 tb/tb_instr_issue_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_unit.sv
// Program store plus PC sequencer: issues one registered instruction per clock and inserts a
// one-cycle NOP bubble on a load-use hazard. A start takes effect on the next edge; `hold` freezes everything except the store.
module instr_issue_unit #(
    parameter int          AW      = 5,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           prog_we,
    input  logic [AW-1:0]  prog_addr,
    input  logic [31:0]    prog_data,
    input  logic           start,
    input  logic           hold,
    output logic [31:0]    Instr,
    output logic           instr_valid,
    output logic [AW-1:0]  pc,
    output logic           busy,
    output logic           done
);

    localparam logic [5:0] OP_NONE = 6'b000000;
    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_AND  = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000110;
    localparam logic [5:0] OP_XOR  = 6'b000111;
    localparam logic [5:0] OP_LW   = 6'b100010;
    localparam logic [5:0] OP_SW   = 6'b100100;

    localparam logic [AW-1:0] ADDR_FIRST = '0;
    localparam logic [AW-1:0] ADDR_LAST  = {AW{1'b1}};
    localparam logic [AW-1:0] ADDR_ONE   = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic [31:0]   mem [2**AW];
    logic [AW-1:0] pc_inc;
    logic [31:0]   next_word;
    logic [31:0]   first_word;
    logic          store_open;
    logic          next_uses_a;
    logic          next_uses_b;
    logic          hazard;

    function automatic logic reads_field_b(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SW: reads_field_b = 1'b1;
            default:                                      reads_field_b = 1'b0;
        endcase
    endfunction

    // pc_inc is never used when pc is the last address, so its wrap is harmless.
    assign pc_inc     = pc + ADDR_ONE;
    assign next_word  = mem[pc_inc];
    assign first_word = mem[ADDR_FIRST];
    assign store_open = (state == IDLE) || (state == DONE);

    assign next_uses_a = (next_word[31:26] != OP_NONE);
    assign next_uses_b = reads_field_b(next_word[31:26]);

    // Load-use: the LW on Instr writes field B, which the following instruction reads.
    assign hazard = (Instr[31:26] == OP_LW) && (Instr[20:16] != 5'd0) &&
                    ((next_uses_a && (next_word[25:21] == Instr[20:16])) ||
                     (next_uses_b && (next_word[20:16] == Instr[20:16])));

    // Not reset: a restart after rst must rerun the loaded program.
    always_ff @(posedge clk) begin
        if (prog_we && store_open) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            Instr       <= 32'h0;
            instr_valid <= 1'b0;
            pc          <= '0;
        end else if (!hold) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (first_word[31:26] == HALT_OP) begin
                            state       <= DONE;
                            Instr       <= 32'h0;
                            instr_valid <= 1'b0;
                        end else begin
                            state       <= RUN;
                            Instr       <= first_word;
                            instr_valid <= 1'b1;
                            pc          <= ADDR_FIRST;
                        end
                    end
                end
                RUN: begin
                    if ((pc == ADDR_LAST) || (next_word[31:26] == HALT_OP)) begin
                        state       <= DONE;
                        Instr       <= 32'h0;
                        instr_valid <= 1'b0;
                    end else if (hazard) begin
                        state       <= BUBBLE;
                        Instr       <= 32'h0;
                        instr_valid <= 1'b0;
                    end else begin
                        Instr       <= next_word;
                        instr_valid <= 1'b1;
                        pc          <= pc_inc;
                    end
                end
                BUBBLE: begin
                    state       <= RUN;
                    Instr       <= next_word;
                    instr_valid <= 1'b1;
                    pc          <= pc_inc;
                end
                default: begin
                    state       <= IDLE;
                    Instr       <= 32'h0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == RUN) || (state == BUBBLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_instr_issue_unit.sv
// Scoreboard bench for instr_issue_unit: stimulus queues the expected outputs for each edge, and a monitor
// compares them one edge later. A second instance with AW=2 covers the end-of-store stop.
module tb_instr_issue_unit;

    localparam logic [5:0] LW   = 6'b100010;
    localparam logic [5:0] ADD  = 6'b000001;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] HALT = 6'b111111;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        hold = 1'b0;

    logic [31:0] Instr, Instr2;
    logic        instr_valid, instr_valid2;
    logic [4:0]  pc;
    logic [1:0]  pc2;
    logic        busy, busy2, done, done2;

    always #5 clk = ~clk;

    instr_issue_unit #(.AW(5)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .hold(hold), .Instr(Instr),
        .instr_valid(instr_valid), .pc(pc), .busy(busy), .done(done)
    );

    instr_issue_unit #(.AW(2)) dut2 (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr[1:0]),
        .prog_data(prog_data), .start(start2), .hold(hold), .Instr(Instr2),
        .instr_valid(instr_valid2), .pc(pc2), .busy(busy2), .done(done2)
    );

    typedef struct {
        bit          sel;
        logic [31:0] instr;
        logic        vld;
        int          pc;
        logic        busy;
        logic        done;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [15:0] imm);
        return {op, a, b, imm};
    endfunction

    task automatic push(input bit sel, input logic [31:0] i, input logic v, input int p,
                        input logic b, input logic d, input string nm);
        exp_t e;
        e.sel = sel; e.instr = i; e.vld = v; e.pc = p; e.busy = b; e.done = d; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic cyc(input logic st, input logic hd, input logic we, input logic [31:0] i,
                       input logic v, input int p, input logic b, input logic d, input string nm);
        @(negedge clk);
        start = st; start2 = 1'b0; hold = hd; prog_we = we;
        push(1'b0, i, v, p, b, d, nm);
    endtask

    task automatic cyc2(input logic st, input logic [31:0] i, input logic v, input int p,
                        input logic b, input logic d, input string nm);
        @(negedge clk);
        start = 1'b0; start2 = st; hold = 1'b0; prog_we = 1'b0;
        push(1'b1, i, v, p, b, d, nm);
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        start = 1'b0; start2 = 1'b0; hold = 1'b0;
        prog_we = 1'b1; prog_addr = a; prog_data = d;
    endtask

    // Monitor: one expectation per clock edge (or async reset edge), sampled 1 time unit later.
    initial begin : monitor
        exp_t        e;
        logic [31:0] ai;
        logic        av, ab, ad;
        logic [7:0]  ap;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel == 1'b0) begin
                    ai = Instr;  av = instr_valid;  ap = {3'b0, pc};  ab = busy;  ad = done;
                end else begin
                    ai = Instr2; av = instr_valid2; ap = {6'b0, pc2}; ab = busy2; ad = done2;
                end
                checks++;
                if (ai !== e.instr || av !== e.vld || ap !== 8'(e.pc) || ab !== e.busy || ad !== e.done) begin
                    errors++;
                    $display("FAIL %s: got Instr=%h vld=%b pc=%0d busy=%b done=%b, want Instr=%h vld=%b pc=%0d busy=%b done=%b",
                             e.nm, ai, av, ap, ab, ad, e.instr, e.vld, e.pc, e.busy, e.done);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] p1 [4];
        logic [31:0] p3 [9];
        logic [31:0] p4 [5];
        logic [31:0] p5 [4];
        logic [31:0] new0;

        p1[0] = mk(LW, 5'd0, 5'd1, 16'h0001);
        p1[1] = mk(LW, 5'd0, 5'd2, 16'h0002);
        p1[2] = mk(ADD, 5'd0, 5'd2, 16'h0000);
        p1[3] = mk(HALT, 5'd0, 5'd0, 16'h0000);

        p3[0] = mk(LW, 5'd0, 5'd0, 16'h0010);
        p3[1] = mk(ADD, 5'd0, 5'd0, 16'h0011);
        p3[2] = mk(LW, 5'd3, 5'd4, 16'h0012);
        p3[3] = mk(ADDI, 5'd4, 5'd9, 16'h0013);
        p3[4] = mk(LW, 5'd0, 5'd6, 16'h0014);
        p3[5] = mk(6'b000000, 5'd6, 5'd6, 16'h0015);
        p3[6] = mk(LW, 5'd0, 5'd7, 16'h0016);
        p3[7] = mk(ADDI, 5'd0, 5'd7, 16'h0017);
        p3[8] = mk(HALT, 5'd0, 5'd0, 16'h0000);

        for (int i = 0; i < 4; i++) p4[i] = mk(ADDI, 5'(i + 1), 5'(i + 10), 16'(16'h0100 + i));
        p4[4] = mk(HALT, 5'd0, 5'd0, 16'h0000);
        new0  = mk(ADDI, 5'd9, 5'd9, 16'h0055);

        for (int i = 0; i < 4; i++) p5[i] = mk(ADDI, 5'(i + 20), 5'd1, 16'(16'h0200 + i));

        // Reset state of both instances.
        rst = 1'b1;
        @(negedge clk); push(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, "reset");
        @(negedge clk); push(1'b1, 32'h0, 1'b0, 0, 1'b0, 1'b0, "reset_aw2");
        @(negedge clk); rst = 1'b0;

        // Basic run with one load-use bubble on field B.
        for (int i = 0; i < 4; i++) load(5'(i), p1[i]);
        cyc(1, 0, 0, p1[0], 1, 0, 1, 0, "basic_i0");
        cyc(0, 0, 0, p1[1], 1, 1, 1, 0, "basic_i1");
        cyc(0, 0, 0, 32'h0, 0, 1, 1, 0, "basic_bubble");
        cyc(0, 0, 0, p1[2], 1, 2, 1, 0, "basic_i2");
        cyc(0, 0, 0, 32'h0, 0, 2, 0, 1, "basic_done");
        cyc(0, 0, 0, 32'h0, 0, 2, 0, 1, "basic_done_stays");

        // Same run with hold for 3 cycles in RUN and 2 in BUBBLE.
        cyc(1, 0, 0, p1[0], 1, 0, 1, 0, "hold_i0");
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, p1[0], 1, 0, 1, 0, "hold_run");
        cyc(0, 0, 0, p1[1], 1, 1, 1, 0, "hold_i1");
        cyc(0, 0, 0, 32'h0, 0, 1, 1, 0, "hold_bubble");
        for (int i = 0; i < 2; i++) cyc(0, 1, 0, 32'h0, 0, 1, 1, 0, "hold_bubble_frozen");
        cyc(0, 0, 0, p1[2], 1, 2, 1, 0, "hold_i2");
        cyc(0, 0, 0, 32'h0, 0, 2, 0, 1, "hold_done");

        // Hazard-free LW cases, a field-A hazard, and start ignored while running.
        for (int i = 0; i < 9; i++) load(5'(i), p3[i]);
        cyc(1, 0, 0, p3[0], 1, 0, 1, 0, "nohaz_i0");
        cyc(0, 0, 0, p3[1], 1, 1, 1, 0, "nohaz_lw_b0");
        cyc(1, 0, 0, p3[2], 1, 2, 1, 0, "nohaz_start_ignored");
        cyc(0, 0, 0, 32'h0, 0, 2, 1, 0, "haz_field_a_bubble");
        cyc(0, 0, 0, p3[3], 1, 3, 1, 0, "haz_i3");
        cyc(0, 0, 0, p3[4], 1, 4, 1, 0, "nohaz_i4");
        cyc(0, 0, 0, p3[5], 1, 5, 1, 0, "nohaz_op0_no_sources");
        cyc(0, 0, 0, p3[6], 1, 6, 1, 0, "nohaz_i6");
        cyc(0, 0, 0, p3[7], 1, 7, 1, 0, "nohaz_addi_b_unused");
        cyc(0, 0, 0, 32'h0, 0, 7, 0, 1, "nohaz_done");

        // Write guard in RUN, then async reset while pc=2.
        for (int i = 0; i < 5; i++) load(5'(i), p4[i]);
        cyc(1, 0, 0, p4[0], 1, 0, 1, 0, "guard_i0");
        prog_addr = 5'd1; prog_data = 32'hDEADBEEF;
        cyc(0, 0, 1, p4[1], 1, 1, 1, 0, "guard_we_in_run");
        cyc(0, 0, 0, p4[2], 1, 2, 1, 0, "guard_i2");
        @(negedge clk);
        #2;
        push(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, "reset_mid_run");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Restart with a simultaneous write to address 0: old word issues first.
        prog_addr = 5'd0; prog_data = new0;
        cyc(1, 0, 1, p4[0], 1, 0, 1, 0, "restart_prewrite_mem0");
        cyc(0, 0, 0, p4[1], 1, 1, 1, 0, "restart_mem1_intact");
        cyc(0, 0, 0, p4[2], 1, 2, 1, 0, "restart_i2");
        cyc(0, 0, 0, p4[3], 1, 3, 1, 0, "restart_i3");
        cyc(0, 0, 0, 32'h0, 0, 3, 0, 1, "restart_done");
        cyc(1, 0, 0, new0,  1, 0, 1, 0, "rerun_new_mem0");
        cyc(0, 0, 0, p4[1], 1, 1, 1, 0, "rerun_mem1_intact");
        cyc(0, 0, 0, p4[2], 1, 2, 1, 0, "rerun_i2");
        cyc(0, 0, 0, p4[3], 1, 3, 1, 0, "rerun_i3");
        cyc(0, 0, 0, 32'h0, 0, 3, 0, 1, "rerun_done");

        // HALT at address 0: straight to DONE, pc keeps its last value.
        load(5'd0, mk(HALT, 5'd0, 5'd0, 16'h0000));
        cyc(1, 0, 0, 32'h0, 0, 3, 0, 1, "halt_at_0");

        // End of store on the AW=2 instance.
        for (int i = 0; i < 4; i++) load(5'(i), p5[i]);
        cyc2(1, p5[0], 1, 0, 1, 0, "eos_i0");
        cyc2(0, p5[1], 1, 1, 1, 0, "eos_i1");
        cyc2(0, p5[2], 1, 2, 1, 0, "eos_i2");
        cyc2(0, p5[3], 1, 3, 1, 0, "eos_i3");
        cyc2(0, 32'h0, 0, 3, 0, 1, "eos_done");

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
